// File: rtl/alu_issue.sv
// Single-issue ALU front end: reads operands (with write-back bypass), holds the ALU for a
// per-opcode number of cycles, then writes the captured result back for one cycle.
module alu_issue #(
  parameter int unsigned MUL_CYCLES = 2,
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_aluop,
  input  logic [3:0]  in_rd,
  input  logic [3:0]  in_rs1,
  input  logic [3:0]  in_rs2,
  input  logic [15:0] in_imm,
  input  logic        in_use_imm,
  output logic [3:0]  rf_raddr1,
  output logic [3:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  output logic [31:0] alu_val1,
  output logic [31:0] alu_val2,
  output logic [4:0]  alu_aluop,
  output logic        alu_is_alu_op,
  input  logic [31:0] alu_result,
  output logic        rf_we,
  output logic [3:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        err,
  output logic        busy
);

  localparam logic [4:0] OpMov  = 5'h00;
  localparam logic [4:0] OpMovl = 5'h02;
  localparam logic [4:0] OpMovh = 5'h03;
  localparam logic [4:0] OpAdd  = 5'h04;
  localparam logic [4:0] OpSub  = 5'h05;
  localparam logic [4:0] OpMul  = 5'h06;
  localparam logic [4:0] OpDiv  = 5'h07;
  localparam logic [4:0] OpAnd  = 5'h08;
  localparam logic [4:0] OpOr   = 5'h09;
  localparam logic [4:0] OpNot  = 5'h0A;
  localparam logic [4:0] OpXor  = 5'h0B;
  localparam logic [4:0] OpShl  = 5'h0C;
  localparam logic [4:0] OpShr  = 5'h0D;
  localparam logic [4:0] OpAsr  = 5'h0E;

  typedef enum logic [1:0] {StIdle, StExec, StWb} state_e;

  state_e      state_q, state_d;
  logic [31:0] val1_q, val1_d, val2_q, val2_d;
  logic [4:0]  aluop_q, aluop_d;
  logic [3:0]  rd_q, rd_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d, err_q, err_d;
  logic [3:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        accept, legal;
  logic [3:0]  last_cnt;
  logic [31:0] src1, src2, op2;

  assign in_ready      = (state_q != StExec);
  assign busy          = (state_q != StIdle);
  assign alu_is_alu_op = (state_q == StExec);
  assign accept        = in_valid && in_ready;

  // MOVL/MOVH merge into the destination, so its old value is operand 1.
  assign rf_raddr1 = (in_aluop == OpMovl || in_aluop == OpMovh) ? in_rd : in_rs1;
  assign rf_raddr2 = in_rs2;

  // Forward the value being written back this cycle; the register file only sees it next edge.
  assign src1 = (rf_we && rf_waddr == rf_raddr1) ? rf_wdata : rf_rdata1;
  assign src2 = (rf_we && rf_waddr == rf_raddr2) ? rf_wdata : rf_rdata2;
  assign op2  = in_use_imm ? {16'h0000, in_imm} : src2;

  always_comb begin
    legal    = 1'b0;
    last_cnt = 4'd0;
    case (in_aluop)
      OpMov, OpMovl, OpMovh, OpAdd, OpSub, OpAnd, OpOr, OpNot, OpXor, OpShl, OpShr,
      OpAsr:   legal = 1'b1;
      OpMul: begin
        legal    = 1'b1;
        last_cnt = 4'(MUL_CYCLES - 1);
      end
      OpDiv: begin
        legal    = 1'b1;
        last_cnt = 4'(DIV_CYCLES - 1);
      end
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    val1_d  = val1_q;
    val2_d  = val2_q;
    aluop_d = aluop_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    we_d    = 1'b0;
    err_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      StIdle, StWb: begin
        state_d = StIdle;
        if (accept) begin
          val1_d  = src1;
          val2_d  = op2;
          aluop_d = in_aluop;
          rd_d    = in_rd;
          if (!legal) begin
            state_d = StWb;
            err_d   = 1'b1;
          end else if (in_aluop == OpDiv && op2 == 32'h0) begin
            state_d = StWb;
            we_d    = 1'b1;
            err_d   = 1'b1;
            waddr_d = in_rd;
            wdata_d = 32'hFFFF_FFFF;
          end else begin
            state_d = StExec;
            cnt_d   = last_cnt;
          end
        end
      end
      StExec: begin
        if (cnt_q == 4'd0) begin
          state_d = StWb;
          we_d    = 1'b1;
          waddr_d = rd_q;
          wdata_d = alu_result;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      val1_q  <= '0;
      val2_q  <= '0;
      aluop_q <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      val1_q  <= val1_d;
      val2_q  <= val2_d;
      aluop_q <= aluop_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign alu_val1  = val1_q;
  assign alu_val2  = val2_q;
  assign alu_aluop = aluop_q;
  assign rf_we     = we_q;
  assign rf_waddr  = waddr_q;
  assign rf_wdata  = wdata_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: sequential-ISA model with a per-cycle expectation queue, a bench-side
// register file and ALU, directed corner cases and randomized instruction streams.
module tb_alu_issue;
  localparam int unsigned MulN = 2;
  localparam int unsigned DivN = 4;

  logic        clk, rst_n, in_valid, in_ready, in_use_imm;
  logic [4:0]  in_aluop, alu_aluop;
  logic [3:0]  in_rd, in_rs1, in_rs2, rf_raddr1, rf_raddr2, rf_waddr;
  logic [15:0] in_imm;
  logic [31:0] rf_rdata1, rf_rdata2, alu_val1, alu_val2, alu_result, rf_wdata;
  logic        alu_is_alu_op, rf_we, err, busy;

  alu_issue #(.MUL_CYCLES(MulN), .DIV_CYCLES(DivN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_aluop(in_aluop), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .alu_val1(alu_val1), .alu_val2(alu_val2),
    .alu_aluop(alu_aluop), .alu_is_alu_op(alu_is_alu_op), .alu_result(alu_result),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .err(err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    case (op)
      5'd0:  return b;
      5'd2:  return {a[31:16], b[15:0]};
      5'd3:  return {b[15:0], a[15:0]};
      5'd4:  return a + b;
      5'd5:  return a - b;
      5'd6:  return a * b;
      5'd7:  return (b == 32'h0) ? 32'h0 : a / b;
      5'd8:  return a & b;
      5'd9:  return a | b;
      5'd10: return ~a;
      5'd11: return a ^ b;
      5'd12: return a << b[4:0];
      5'd13: return a >> b[4:0];
      5'd14: return $signed(a) >>> b[4:0];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic is_legal(input logic [4:0] op);
    return (op == 5'd0) || (op >= 5'd2 && op <= 5'd14);
  endfunction

  // Bench register file: the DUT writes it back, the bench may preload it when quiet.
  logic [31:0] phys_rf [16];
  logic        tb_we;
  logic [3:0]  tb_waddr;
  logic [31:0] tb_wdata;
  assign rf_rdata1  = phys_rf[rf_raddr1];
  assign rf_rdata2  = phys_rf[rf_raddr2];
  assign alu_result = alu_fn(alu_aluop, alu_val1, alu_val2);
  always @(posedge clk) begin
    if (tb_we) phys_rf[tb_waddr] <= tb_wdata;
    else if (rf_we) phys_rf[rf_waddr] <= rf_wdata;
  end

  typedef struct {
    int          kind;  // 0 idle, 1 exec, 2 write-back
    logic [31:0] v1, v2;
    logic [4:0]  op;
    logic        we, err;
    logic [3:0]  waddr;
    logic [31:0] wdata;
  } rec_t;

  typedef struct {
    logic        gap;
    logic [4:0]  op;
    logic [3:0]  rd, rs1, rs2;
    logic [15:0] imm;
    logic        use_imm;
  } ins_t;

  rec_t        exp_q[$];
  ins_t        nq[$];
  logic [31:0] arch [16];
  logic [31:0] last_v1, last_v2, last_exec_v1, last_exec_v2;
  logic [4:0]  last_op;
  logic [3:0]  acc_raddr1;
  logic        acc_pending;
  int          tests, fails, exec_seen, err_seen;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_accept();
    logic [3:0]  ra1;
    logic [31:0] v1, v2;
    rec_t        r;
    int          n;
    ra1        = (in_aluop == 5'd2 || in_aluop == 5'd3) ? in_rd : in_rs1;
    acc_raddr1 = ra1;
    v1         = arch[ra1];
    v2         = in_use_imm ? {16'h0, in_imm} : arch[in_rs2];
    last_v1    = v1;
    last_v2    = v2;
    last_op    = in_aluop;
    r.v1 = v1; r.v2 = v2; r.op = in_aluop; r.we = 1'b0; r.err = 1'b0;
    r.waddr = in_rd; r.wdata = 32'h0;
    if (!is_legal(in_aluop)) begin
      r.kind = 2; r.err = 1'b1;
      exp_q.push_back(r);
    end else if (in_aluop == 5'd7 && v2 == 32'h0) begin
      r.kind = 2; r.we = 1'b1; r.err = 1'b1; r.wdata = 32'hFFFF_FFFF;
      exp_q.push_back(r);
    end else begin
      n = (in_aluop == 5'd6) ? int'(MulN) : (in_aluop == 5'd7) ? int'(DivN) : 1;
      r.kind = 1;
      repeat (n) exp_q.push_back(r);
      r.kind = 2; r.we = 1'b1; r.wdata = alu_fn(in_aluop, v1, v2);
      exp_q.push_back(r);
    end
  endtask

  // One cycle: check this cycle's outputs, then drive and resolve the next offer.
  task automatic tick();
    rec_t cur;
    @(negedge clk);
    cur.kind = 0;
    if (exp_q.size() > 0) cur = exp_q.pop_front();
    chk1("in_ready", in_ready, cur.kind != 1);
    chk1("busy", busy, cur.kind != 0);
    chk1("alu_is_alu_op", alu_is_alu_op, cur.kind == 1);
    chk("alu_val1", alu_val1, last_v1);
    chk("alu_val2", alu_val2, last_v2);
    chk("alu_aluop", 32'(alu_aluop), 32'(last_op));
    chk1("rf_we", rf_we, cur.kind == 2 && cur.we);
    chk1("err", err, cur.kind == 2 && cur.err);
    if (cur.kind == 2 && cur.we) begin
      chk("rf_waddr", 32'(rf_waddr), 32'(cur.waddr));
      chk("rf_wdata", rf_wdata, cur.wdata);
      arch[cur.waddr] = cur.wdata;
    end
    if (alu_is_alu_op) begin
      exec_seen++;
      last_exec_v1 = alu_val1;
      last_exec_v2 = alu_val2;
    end
    if (err) err_seen++;
    if (acc_pending) begin
      in_valid    = 1'b0;
      acc_pending = 1'b0;
    end
    if (!in_valid && nq.size() > 0) begin
      ins_t i;
      i = nq.pop_front();
      if (!i.gap) begin
        in_valid = 1'b1; in_aluop = i.op; in_rd = i.rd; in_rs1 = i.rs1; in_rs2 = i.rs2;
        in_imm = i.imm; in_use_imm = i.use_imm;
      end
    end
    #1;
    if (in_valid) begin
      chk("rf_raddr1", 32'(rf_raddr1),
          32'((in_aluop == 5'd2 || in_aluop == 5'd3) ? in_rd : in_rs1));
      chk("rf_raddr2", 32'(rf_raddr2), 32'(in_rs2));
      if (cur.kind != 1) begin
        model_accept();
        acc_pending = 1'b1;
      end
    end
  endtask

  task automatic push(input logic [4:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                      input logic [3:0] rs2, input logic [15:0] imm, input logic use_imm);
    ins_t i;
    i.gap = 1'b0; i.op = op; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.imm = imm;
    i.use_imm = use_imm;
    nq.push_back(i);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((nq.size() > 0 || in_valid || exp_q.size() > 0) && n < 3000) begin
      tick();
      n++;
    end
    chk1("drain_timeout", n >= 3000, 1'b0);
    tick();  // let the final write-back land in the bench register file
  endtask

  task automatic set_reg(input logic [3:0] idx, input logic [31:0] val);
    arch[idx] = val;
    tb_we = 1'b1; tb_waddr = idx; tb_wdata = val;
    tick();
    tb_we = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_in_ready"}, in_ready, 1'b1);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_alu_is_alu_op"}, alu_is_alu_op, 1'b0);
    chk1({tag, "_rf_we"}, rf_we, 1'b0);
    chk1({tag, "_err"}, err, 1'b0);
    chk({tag, "_alu_val1"}, alu_val1, 32'h0);
    chk({tag, "_alu_val2"}, alu_val2, 32'h0);
    chk({tag, "_alu_aluop"}, 32'(alu_aluop), 32'h0);
    chk({tag, "_rf_waddr"}, 32'(rf_waddr), 32'h0);
    chk({tag, "_rf_wdata"}, rf_wdata, 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish by %0t", $time);
    $fatal(1);
  end

  initial begin
    int e0, r0, n;
    logic [4:0] legal_ops [14];
    legal_ops = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11,
                  5'd12, 5'd13, 5'd14};
    tests = 0; fails = 0; exec_seen = 0; err_seen = 0; acc_pending = 1'b0;
    last_v1 = '0; last_v2 = '0; last_op = '0; last_exec_v1 = '0; last_exec_v2 = '0;
    acc_raddr1 = '0;
    rst_n = 1'b0; in_valid = 1'b0; in_aluop = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; in_use_imm = 1'b0; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) set_reg(4'(i), $urandom);

    // ADD 8+8
    set_reg(4'd1, 32'd8);
    set_reg(4'd2, 32'd8);
    e0 = exec_seen;
    push(5'd4, 4'd3, 4'd1, 4'd2, 16'h0, 1'b0);
    wait_idle();
    chk("add_result", phys_rf[3], 32'h10);
    chk("add_exec_cycles", 32'(exec_seen - e0), 32'd1);
    chk("add_val1", last_exec_v1, 32'd8);

    // MUL 8*8 holds the ALU for two cycles
    e0 = exec_seen;
    push(5'd6, 4'd4, 4'd1, 4'd2, 16'h0, 1'b0);
    wait_idle();
    chk("mul_result", phys_rf[4], 32'h40);
    chk("mul_exec_cycles", 32'(exec_seen - e0), 32'd2);

    // Back-to-back with bypass of the value being written back
    push(5'd4, 4'd1, 4'd1, 4'd2, 16'h0, 1'b0);
    push(5'd5, 4'd2, 4'd1, 4'd1, 16'h0, 1'b0);
    wait_idle();
    chk("bypass_val1", last_exec_v1, 32'h10);
    chk("bypass_val2", last_exec_v2, 32'h10);
    chk("bypass_r1", phys_rf[1], 32'h10);
    chk("bypass_r2", phys_rf[2], 32'h0);

    // Illegal opcodes
    set_reg(4'd5, 32'h55);
    r0 = err_seen; e0 = exec_seen;
    push(5'h01, 4'd5, 4'd1, 4'd1, 16'h0, 1'b0);
    push(5'h1F, 4'd5, 4'd1, 4'd1, 16'h0, 1'b0);
    wait_idle();
    chk("illegal_err_pulses", 32'(err_seen - r0), 32'd2);
    chk("illegal_no_exec", 32'(exec_seen - e0), 32'd0);
    chk("illegal_no_write", phys_rf[5], 32'h55);

    // Divide by zero
    set_reg(4'd6, 32'h0);
    r0 = err_seen; e0 = exec_seen;
    push(5'd7, 4'd7, 4'd1, 4'd6, 16'h0, 1'b0);
    wait_idle();
    chk("divz_result", phys_rf[7], 32'hFFFF_FFFF);
    chk("divz_err", 32'(err_seen - r0), 32'd1);
    chk("divz_no_exec", 32'(exec_seen - e0), 32'd0);

    // Immediate operand and MOVL reading its destination
    push(5'd0, 4'd8, 4'd1, 4'd2, 16'hBEEF, 1'b1);
    wait_idle();
    chk("mov_imm_val2", last_exec_v2, 32'h0000_BEEF);
    chk("mov_imm_result", phys_rf[8], 32'h0000_BEEF);
    set_reg(4'd9, 32'hAAAA_0000);
    push(5'd2, 4'd9, 4'd5, 4'd2, 16'h1234, 1'b1);
    wait_idle();
    chk("movl_raddr1", 32'(acc_raddr1), 32'd9);
    chk("movl_result", phys_rf[9], 32'hAAAA_1234);

    // Reset in the second EXEC cycle of a DIV aborts it
    set_reg(4'd10, 32'h1234_5678);
    set_reg(4'd11, 32'd3);
    push(5'd7, 4'd10, 4'd11, 4'd11, 16'h0, 1'b0);
    n = 0;
    while (!acc_pending && n < 20) begin
      tick();
      n++;
    end
    chk1("div_accept_timeout", acc_pending, 1'b1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    exp_q.delete();
    last_v1 = '0; last_v2 = '0; last_op = '0;
    @(negedge clk);
    rst_n = 1'b1;
    push(5'd4, 4'd12, 4'd11, 4'd11, 16'h0, 1'b0);
    wait_idle();
    chk("rst_no_write", phys_rf[10], 32'h1234_5678);
    chk("post_rst_add", phys_rf[12], 32'd6);

    // Randomized stream
    for (int k = 0; k < 400; k++) begin
      ins_t i;
      i.gap = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) begin
        int r = $urandom_range(0, 17);
        i.op = (r == 0) ? 5'd1 : 5'(14 + r);
      end else begin
        i.op = legal_ops[$urandom_range(0, 13)];
      end
      i.rd = 4'($urandom); i.rs1 = 4'($urandom); i.rs2 = 4'($urandom);
      i.use_imm = ($urandom_range(0, 2) == 0);
      i.imm = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom);
      nq.push_back(i);
    end
    wait_idle();
    for (int i = 0; i < 16; i++) chk($sformatf("final_r%0d", i), phys_rf[i], arch[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
